// File: rtl/dispatch_pkg.sv
// Shared definitions for the instruction dispatcher and the ALU FSM it drives:
// dispatcher states, instruction field layout and opcode constants.
package dispatch_pkg;

    localparam int OPCODE_W = 4;
    localparam int ADDR_W   = 6;
    localparam int INSTR_W  = OPCODE_W + 2 * ADDR_W;

    localparam logic [15:0] DEFAULT_LEGAL_MASK = 16'h00FF;

    // Opcodes understood by the ALU FSM
    localparam logic [OPCODE_W-1:0] OP_NOP = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_AND = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_OR  = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_XOR = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_SHL = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_SHR = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } state_t;

endpackage

// File: rtl/instr_queue2.sv
// Two-entry instruction FIFO: valid/ready on the write side, pop/empty with a
// combinational head on the read side so the dispatcher can decode before popping.
module instr_queue2
    import dispatch_pkg::*;
#(
    parameter int W = INSTR_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         ready_en_reg;
    logic         push;
    logic         do_pop;

    // ready stays low until the first edge after reset is released
    assign in_ready = ready_en_reg && (count_reg != 2'd2);
    assign empty    = (count_reg == 2'd0);
    assign push     = in_valid && in_ready;
    assign do_pop   = pop && !empty;
    assign head     = mem[rd_ptr_reg];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            if (push)   wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop) rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + 2'(push) - 2'(do_pop);
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clock) begin
                if (push && (wr_ptr_reg == 1'(gi)))
                    mem[gi] <= in_data;
            end
        end
    endgenerate

endmodule

// File: rtl/instr_dispatch.sv
// Initiator side of the ALU FSM start/done handshake: queues and decodes
// instructions, issues them one at a time, screens opcodes and times out hung ops.
module instr_dispatch
    import dispatch_pkg::*;
#(
    parameter int                  OPW        = OPCODE_W,
    parameter int                  ADDRW      = ADDR_W,
    parameter int                  TIMEOUT    = 32,
    parameter logic [2**OPW-1:0]   LEGAL_MASK = DEFAULT_LEGAL_MASK,
    parameter int                  CNTW       = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [OPW+2*ADDRW-1:0] instr_word,
    output logic                   FSM_start,
    output logic [OPW-1:0]         opcode,
    output logic [ADDRW-1:0]       param1,
    output logic [ADDRW-1:0]       param2,
    input  logic                   done,
    output logic                   busy,
    output logic [CNTW-1:0]        retired_count,
    output logic                   err_illegal,
    output logic                   err_timeout,
    input  logic                   clear_err
);

    localparam int IW = OPW + 2 * ADDRW;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [TW-1:0]     tmo_reg, tmo_next;
    logic [CNTW-1:0]   count_reg, count_next;
    logic [OPW-1:0]    op_reg;
    logic [ADDRW-1:0]  p1_reg, p2_reg;
    logic              ill_reg, tmo_err_reg;
    logic              ill_set, tmo_set;
    logic              q_empty, q_pop;
    logic [IW-1:0]     q_head;
    logic [OPW-1:0]    head_op;

    instr_queue2 #(.W(IW)) u_queue (
        .clock    (clock),
        .reset    (reset),
        .in_valid (instr_valid),
        .in_ready (instr_ready),
        .in_data  (instr_word),
        .pop      (q_pop),
        .empty    (q_empty),
        .head     (q_head)
    );

    assign head_op = q_head[IW-1 -: OPW];

    always_comb begin
        state_next = state_reg;
        tmo_next   = tmo_reg;
        count_next = count_reg;
        q_pop      = 1'b0;
        ill_set    = 1'b0;
        tmo_set    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!q_empty) begin
                    q_pop = 1'b1;
                    if (LEGAL_MASK[head_op]) state_next = ST_ISSUE;
                    else                     ill_set    = 1'b1;
                end
            end
            ST_ISSUE: begin
                tmo_next   = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // done takes priority over an expiring timeout on the same cycle
                if (done) begin
                    count_next = count_reg + CNTW'(1);
                    state_next = ST_RETIRE;
                end else if (tmo_reg == TMO_LAST) begin
                    tmo_set    = 1'b1;
                    state_next = ST_RETIRE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            ST_RETIRE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            tmo_reg     <= '0;
            count_reg   <= '0;
            op_reg      <= '0;
            p1_reg      <= '0;
            p2_reg      <= '0;
            ill_reg     <= 1'b0;
            tmo_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            tmo_reg   <= tmo_next;
            count_reg <= count_next;
            if (q_pop) begin
                op_reg <= q_head[IW-1 -: OPW];
                p1_reg <= q_head[2*ADDRW-1 -: ADDRW];
                p2_reg <= q_head[ADDRW-1:0];
            end
            ill_reg     <= ill_set || (ill_reg && !clear_err);
            tmo_err_reg <= tmo_set || (tmo_err_reg && !clear_err);
        end
    end

    assign FSM_start     = (state_reg == ST_ISSUE);
    assign busy          = (state_reg != ST_IDLE);
    assign opcode        = op_reg;
    assign param1        = p1_reg;
    assign param2        = p2_reg;
    assign retired_count = count_reg;
    assign err_illegal   = ill_reg;
    assign err_timeout   = tmo_err_reg;

endmodule

// File: tb/tb_instr_dispatch.sv
// Bench for instr_dispatch: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the dispatcher.
module tb_instr_dispatch;
    import dispatch_pkg::*;

    localparam int TIMEOUT = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr_word = 16'h0;
    logic        done = 1'b0;
    logic        clear_err = 1'b0;
    logic        instr_ready, FSM_start, busy, err_illegal, err_timeout;
    logic [3:0]  opcode;
    logic [5:0]  param1, param2;
    logic [7:0]  retired_count;

    instr_dispatch dut (
        .clock         (clock),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_word    (instr_word),
        .FSM_start     (FSM_start),
        .opcode        (opcode),
        .param1        (param1),
        .param2        (param2),
        .done          (done),
        .busy          (busy),
        .retired_count (retired_count),
        .err_illegal   (err_illegal),
        .err_timeout   (err_timeout),
        .clear_err     (clear_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // model: pending words, the instruction in flight and its progress
    logic [15:0] mq[$];
    logic [15:0] m_word;
    bit          m_ready_en, m_busy, m_starting, m_retiring, m_ill, m_tmo;
    int          m_waited;
    logic [7:0]  m_count;

    // ALU emulation
    int alu_cnt = 0;
    int alu_lat = 10;
    bit alu_hang = 0, alu_rand = 0, stray_en = 0;

    function automatic bit legal(input logic [3:0] op);
        return op < 4'd8;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name, input int n);
        total++;
        bad++;
        $display("FAIL %s: gave up after %0d cycles, required completion", name, n);
    endtask

    task automatic model_reset();
        mq.delete();
        m_word = 16'h0; m_ready_en = 0; m_busy = 0; m_starting = 0;
        m_retiring = 0; m_ill = 0; m_tmo = 0; m_waited = 0; m_count = 8'h0;
    endtask

    task automatic model_step();
        bit push, ill_set, tmo_set;
        logic [15:0] w;
        if (!reset) return;
        push    = instr_valid && m_ready_en && (mq.size() < 2);
        ill_set = 0;
        tmo_set = 0;
        if (!m_busy) begin
            if (mq.size() > 0) begin
                w = mq.pop_front();
                m_word = w;
                if (legal(w[15:12])) begin
                    m_busy = 1;
                    m_starting = 1;
                end else ill_set = 1;
            end
        end else if (m_starting) begin
            m_starting = 0;
            m_waited = 0;
        end else if (m_retiring) begin
            m_retiring = 0;
            m_busy = 0;
        end else begin
            m_waited++;
            if (done) begin
                m_count++;
                m_retiring = 1;
            end else if (m_waited == TIMEOUT) begin
                tmo_set = 1;
                m_retiring = 1;
            end
        end
        if (push) mq.push_back(instr_word);
        m_ill = ill_set || (m_ill && !clear_err);
        m_tmo = tmo_set || (m_tmo && !clear_err);
        m_ready_en = 1;
    endtask

    always @(negedge clock) begin
        check("instr_ready", instr_ready, m_ready_en && (mq.size() < 2));
        check("FSM_start", FSM_start, m_starting);
        check("busy", busy, m_busy);
        check("opcode", opcode, m_word[15:12]);
        check("param1", param1, m_word[11:6]);
        check("param2", param2, m_word[5:0]);
        check("retired_count", retired_count, m_count);
        check("err_illegal", err_illegal, m_ill);
        check("err_timeout", err_timeout, m_tmo);
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        done = 1'b0;
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) done = 1'b1;
        end
        if (FSM_start) begin
            if (alu_rand) alu_cnt = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
            else          alu_cnt = alu_hang ? 0 : alu_lat;
        end
        if (stray_en && $urandom_range(0, 31) == 0) done = 1'b1;
    endtask

    task automatic send(input logic [15:0] w);
        int n;
        bit acc;
        instr_word  = w;
        instr_valid = 1'b1;
        n = 0;
        do begin
            acc = m_ready_en && (mq.size() < 2);
            tick();
            n++;
        end while (!acc && n < 300);
        instr_valid = 1'b0;
        if (!acc) bound_fail("send", n);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || mq.size() > 0) && n < 500) begin
            tick();
            n++;
        end
        if (m_busy || mq.size() > 0) bound_fail("wait_idle", n);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    task automatic assert_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        int n;
        logic [15:0] w;
        model_reset();

        // reset state and ready release
        tick();
        check("rst_ready", instr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_count", retired_count, 0);
        tick();
        reset = 1'b1;
        check("ready_before_edge", instr_ready, 0);
        tick();
        check("ready_after_edge", instr_ready, 1);

        // basic flow: done 10 cycles after start
        alu_lat = 10;
        send(16'h1041);
        tick();
        check("basic_start", FSM_start, 1);
        check("basic_operands", {opcode, param1, param2}, 16'h1041);
        repeat (10) tick();
        check("basic_busy_at_done", busy, 1);
        tick();
        check("basic_count", retired_count, 1);
        check("basic_retire_busy", busy, 1);
        check("basic_hold", {opcode, param1, param2}, 16'h1041);
        tick();
        check("basic_busy_fall", busy, 0);

        // back-to-back with backpressure
        alu_lat = 20;
        send({OP_SUB, 12'h001});
        send({OP_AND, 12'h002});
        send({OP_OR, 12'h003});
        check("bp_ready_low", instr_ready, 0);
        send({OP_XOR, 12'h004});
        wait_idle();
        check("bp_count", retired_count, 5);

        // illegal opcode is dropped, next word issues
        send(16'hA000);
        send(16'h2082);
        wait_idle();
        check("illegal_flag", err_illegal, 1);
        check("illegal_count", retired_count, 6);
        pulse_clear();
        check("illegal_cleared", err_illegal, 0);

        // timeout after 32 WAIT cycles
        alu_hang = 1;
        send(16'h1041);
        n = 0;
        while (!FSM_start && n < 10) begin tick(); n++; end
        n = 0;
        while (!err_timeout && n < 100) begin tick(); n++; end
        check("timeout_cycles", n, 33);
        check("timeout_count", retired_count, 6);
        wait_idle();
        pulse_clear();
        alu_hang = 0;
        alu_lat = 32;
        send(16'h3003);
        wait_idle();
        check("boundary_done_count", retired_count, 7);
        check("boundary_done_noerr", err_timeout, 0);
        alu_lat = 33;
        send(16'h4004);
        wait_idle();
        check("late_done_count", retired_count, 7);
        check("late_done_err", err_timeout, 1);
        pulse_clear();

        // stray done in IDLE, then reset in WAIT with 2 queued
        done = 1'b1;
        tick();
        check("stray_count", retired_count, 7);
        check("stray_busy", busy, 0);
        alu_hang = 1;
        send(16'h1041);
        send(16'h2082);
        send(16'h3003);
        repeat (3) tick();
        check("pre_reset_busy", busy, 1);
        assert_reset();
        check("arst_ready", instr_ready, 0);
        check("arst_start", FSM_start, 0);
        check("arst_busy", busy, 0);
        check("arst_operands", {opcode, param1, param2}, 0);
        check("arst_count", retired_count, 0);
        alu_hang = 0;
        alu_cnt = 6;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_reset_ready", instr_ready, 1);
        repeat (6) tick();
        check("post_reset_count", retired_count, 0);
        check("post_reset_busy", busy, 0);

        // counter wrap
        alu_lat = 1;
        for (int i = 0; i < 255; i++) begin
            w = {1'b0, 15'($urandom)};
            send(w);
        end
        wait_idle();
        check("wrap_255", retired_count, 255);
        send(16'h7123);
        wait_idle();
        check("wrap_0", retired_count, 0);

        // randomized traffic
        alu_rand = 1;
        stray_en = 1;
        for (int i = 0; i < 3000; i++) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr_word  = ($urandom_range(0, 4) == 0) ? {1'b1, 15'($urandom)} : {1'b0, 15'($urandom)};
            clear_err   = ($urandom_range(0, 19) == 0);
            tick();
            if (i == 1500) begin
                assert_reset();
                tick();
                reset = 1'b1;
            end
        end
        instr_valid = 1'b0;
        clear_err = 1'b0;
        stray_en = 0;
        alu_rand = 0;
        alu_lat = 3;
        wait_idle();
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
